// File: rtl/cdb_defs_pkg.sv
// Shared constants for the common-data-bus arbiter: default widths,
// functional-unit indices and a circular index helper.
package cdb_defs_pkg;

    localparam int NUM_FU = 4;
    localparam int DATA_W = 16;
    localparam int TAG_W  = 3;
    localparam int SRC_W  = 2;

    localparam logic [SRC_W-1:0] FU_ALU0 = 2'd0;
    localparam logic [SRC_W-1:0] FU_ALU1 = 2'd1;
    localparam logic [SRC_W-1:0] FU_BRU  = 2'd2;
    localparam logic [SRC_W-1:0] FU_LSU  = 2'd3;

    // Next requester index in circular order, wrapping from num-1 back to 0.
    function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx, input int num);
        int j;
        j = int'(idx) + 1;
        if (j >= num) begin
            j = 0;
        end
        return j[SRC_W-1:0];
    endfunction

endpackage

// File: rtl/cdb_pick.sv
// Combinational picker: returns the first valid requester found scanning
// circularly from a start index, optionally skipping one excluded index.
module cdb_pick
    import cdb_defs_pkg::*;
#(
    parameter int NUM_REQ = NUM_FU
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [SRC_W-1:0]   i_start,
    input  logic               i_excl_en,
    input  logic [SRC_W-1:0]   i_excl,
    output logic               o_found,
    output logic [SRC_W-1:0]   o_idx
);

    // Circular priority scan; the first hit that is not the excluded index wins.
    always_comb begin
        int j;
        logic [SRC_W-1:0] idx;
        o_found = 1'b0;
        o_idx   = '0;
        j       = 0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(i_start) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            idx = j[SRC_W-1:0];
            if (!o_found && i_valid[idx] && !(i_excl_en && (idx == i_excl))) begin
                o_found = 1'b1;
                o_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants up to two functional-unit results per
// cycle and broadcasts them on two registered CDB ports one cycle later.
// Default grant policy is round-robin from a rotating pointer. Defining
// CDB_AGE_PRIORITY_EN switches to oldest-first by ROB age relative to
// rob_head (ties to the lower index) and removes the pointer.
module cdb_arbiter #(
    parameter int NUM_REQ = cdb_defs_pkg::NUM_FU,
    parameter int DATA_W  = cdb_defs_pkg::DATA_W,
    parameter int TAG_W   = cdb_defs_pkg::TAG_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [TAG_W-1:0]          rob_head,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_value,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cdb0_valid,
    output logic                      cdb1_valid,
    output logic [TAG_W-1:0]          cdb0_tag,
    output logic [TAG_W-1:0]          cdb1_tag,
    output logic [DATA_W-1:0]         cdb0_value,
    output logic [DATA_W-1:0]         cdb1_value,
    output logic [1:0]                cdb0_src,
    output logic [1:0]                cdb1_src
);

    import cdb_defs_pkg::SRC_W;
    import cdb_defs_pkg::next_idx;

    logic             w_arb_en;
    logic             w_g0_found;
    logic             w_g1_found;
    logic [SRC_W-1:0] w_g0_idx;
    logic [SRC_W-1:0] w_g1_idx;

    logic              r_cdb0_valid;
    logic              r_cdb1_valid;
    logic [TAG_W-1:0]  r_cdb0_tag;
    logic [TAG_W-1:0]  r_cdb1_tag;
    logic [DATA_W-1:0] r_cdb0_value;
    logic [DATA_W-1:0] r_cdb1_value;
    logic [SRC_W-1:0]  r_cdb0_src;
    logic [SRC_W-1:0]  r_cdb1_src;

    // Nothing is granted while reset is held or while the pipeline flushes.
    assign w_arb_en = rst & ~flush;

`ifdef CDB_AGE_PRIORITY_EN

    // Oldest-first selection: smallest (tag - rob_head) wins, strict compare keeps the lower index on ties.
    always_comb begin
        logic [TAG_W-1:0] age;
        logic [TAG_W-1:0] best0;
        logic [TAG_W-1:0] best1;
        age        = '0;
        best0      = '0;
        best1      = '0;
        w_g0_found = 1'b0;
        w_g0_idx   = '0;
        w_g1_found = 1'b0;
        w_g1_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            age = req_tag[i*TAG_W +: TAG_W] - rob_head;
            if (req_valid[i] && (!w_g0_found || (age < best0))) begin
                w_g0_found = 1'b1;
                w_g0_idx   = i[SRC_W-1:0];
                best0      = age;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            age = req_tag[i*TAG_W +: TAG_W] - rob_head;
            if (req_valid[i] && (i[SRC_W-1:0] != w_g0_idx) && (!w_g1_found || (age < best1))) begin
                w_g1_found = 1'b1;
                w_g1_idx   = i[SRC_W-1:0];
                best1      = age;
            end
        end
    end

`else

    logic [SRC_W-1:0] r_rr_ptr;
    logic [SRC_W-1:0] w_g1_start;
    logic             w_unused_rob_head;

    // ROB head only matters for age-ordered arbitration.
    assign w_unused_rob_head = ^rob_head;
    assign w_g1_start        = next_idx(w_g0_idx, NUM_REQ);

    cdb_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick_g0 (
        .i_valid   (req_valid),
        .i_start   (r_rr_ptr),
        .i_excl_en (1'b0),
        .i_excl    ('0),
        .o_found   (w_g0_found),
        .o_idx     (w_g0_idx)
    );

    cdb_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick_g1 (
        .i_valid   (req_valid),
        .i_start   (w_g1_start),
        .i_excl_en (1'b1),
        .i_excl    (w_g0_idx),
        .o_found   (w_g1_found),
        .o_idx     (w_g1_idx)
    );

    // Rotate the pointer past the last winner; idle and flush cycles leave it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= '0;
        end else if (w_arb_en && w_g0_found) begin
            r_rr_ptr <= w_g1_found ? next_idx(w_g1_idx, NUM_REQ) : next_idx(w_g0_idx, NUM_REQ);
        end
    end

`endif

    // Same-cycle grant back to the winning functional units.
    always_comb begin
        req_ready = '0;
        if (w_arb_en) begin
            if (w_g0_found) begin
                req_ready[w_g0_idx] = 1'b1;
            end
            if (w_g1_found) begin
                req_ready[w_g1_idx] = 1'b1;
            end
        end
    end

    // Launch winners onto the CDB: g0 on port 0, g1 on port 1; payload only reloads on a grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cdb0_valid <= 1'b0;
            r_cdb1_valid <= 1'b0;
            r_cdb0_tag   <= '0;
            r_cdb1_tag   <= '0;
            r_cdb0_value <= '0;
            r_cdb1_value <= '0;
            r_cdb0_src   <= '0;
            r_cdb1_src   <= '0;
        end else begin
            r_cdb0_valid <= w_arb_en & w_g0_found;
            r_cdb1_valid <= w_arb_en & w_g1_found;
            if (w_arb_en && w_g0_found) begin
                r_cdb0_tag   <= req_tag[w_g0_idx*TAG_W +: TAG_W];
                r_cdb0_value <= req_value[w_g0_idx*DATA_W +: DATA_W];
                r_cdb0_src   <= w_g0_idx;
            end
            if (w_arb_en && w_g1_found) begin
                r_cdb1_tag   <= req_tag[w_g1_idx*TAG_W +: TAG_W];
                r_cdb1_value <= req_value[w_g1_idx*DATA_W +: DATA_W];
                r_cdb1_src   <= w_g1_idx;
            end
        end
    end

    assign cdb0_valid = r_cdb0_valid;
    assign cdb1_valid = r_cdb1_valid;
    assign cdb0_tag   = r_cdb0_tag;
    assign cdb1_tag   = r_cdb1_tag;
    assign cdb0_value = r_cdb0_value;
    assign cdb1_value = r_cdb1_value;
    assign cdb0_src   = r_cdb0_src;
    assign cdb1_src   = r_cdb1_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter. Covers reset, round-robin fairness,
// pointer wrap with a single grant, flush, idle and flush-during-reset.
// With CDB_AGE_PRIORITY_EN defined it runs the age-priority scenarios instead.
module tb_cdb_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 16;
    localparam int TAG_W   = 3;

    typedef struct {
        logic [3:0] v;
        logic [3:0] r;
        logic       e0;
        logic [1:0] s0;
        logic       e1;
        logic [1:0] s1;
    } vec_t;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      flush = 1'b0;
    logic [TAG_W-1:0]          rob_head = '0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*TAG_W-1:0]  req_tag = '0;
    logic [NUM_REQ*DATA_W-1:0] req_value = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      cdb0_valid;
    logic                      cdb1_valid;
    logic [TAG_W-1:0]          cdb0_tag;
    logic [TAG_W-1:0]          cdb1_tag;
    logic [DATA_W-1:0]         cdb0_value;
    logic [DATA_W-1:0]         cdb1_value;
    logic [1:0]                cdb0_src;
    logic [1:0]                cdb1_src;

    logic [TAG_W-1:0]  expTag [NUM_REQ];
    logic [DATA_W-1:0] expVal [NUM_REQ];

    int numChecks = 0;
    int numErrors = 0;

    cdb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .TAG_W   (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .rob_head   (rob_head),
        .req_valid  (req_valid),
        .req_tag    (req_tag),
        .req_value  (req_value),
        .req_ready  (req_ready),
        .cdb0_valid (cdb0_valid),
        .cdb1_valid (cdb1_valid),
        .cdb0_tag   (cdb0_tag),
        .cdb1_tag   (cdb1_tag),
        .cdb0_value (cdb0_value),
        .cdb1_value (cdb1_value),
        .cdb0_src   (cdb0_src),
        .cdb1_src   (cdb1_src)
    );

    always #5 clk = ~clk;

    task automatic setFu(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] val);
        req_tag[i*TAG_W +: TAG_W]    = t;
        req_value[i*DATA_W +: DATA_W] = val;
        expTag[i] = t;
        expVal[i] = val;
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic f);
        req_valid = v;
        flush     = f;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            setFu(i, TAG_W'(i + 1), 16'hA000 + 16'(i * 16'h0111));
        end
        rst = 1'b0;
        applyStimulus(4'b1111, 1'b0);
        advance();
        advance();
        numChecks++;
        if (req_ready !== 4'b0000) begin
            numErrors++;
            $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready);
        end
        numChecks++;
        if ({cdb0_valid, cdb0_src, cdb0_tag, cdb0_value} !== '0) begin
            numErrors++;
            $display("[TB] FAIL reset_port0: got v=%b src=%0d tag=%0d val=%h expected all zero", cdb0_valid, cdb0_src, cdb0_tag, cdb0_value);
        end
        numChecks++;
        if ({cdb1_valid, cdb1_src, cdb1_tag, cdb1_value} !== '0) begin
            numErrors++;
            $display("[TB] FAIL reset_port1: got v=%b src=%0d tag=%0d val=%h expected all zero", cdb1_valid, cdb1_src, cdb1_tag, cdb1_value);
        end
        rst = 1'b1;
        #1;
        numChecks++;
        if (req_ready !== 4'b0011) begin
            numErrors++;
            $display("[TB] FAIL release_ready: got %b expected 0011", req_ready);
        end
        advance();
        numChecks++;
        if ({cdb0_valid, cdb0_src, cdb0_tag, cdb0_value} !== {1'b1, 2'd0, expTag[0], expVal[0]}) begin
            numErrors++;
            $display("[TB] FAIL release_port0: got v=%b src=%0d tag=%0d val=%h expected src 0", cdb0_valid, cdb0_src, cdb0_tag, cdb0_value);
        end
        numChecks++;
        if ({cdb1_valid, cdb1_src, cdb1_tag, cdb1_value} !== {1'b1, 2'd1, expTag[1], expVal[1]}) begin
            numErrors++;
            $display("[TB] FAIL release_port1: got v=%b src=%0d tag=%0d val=%h expected src 1", cdb1_valid, cdb1_src, cdb1_tag, cdb1_value);
        end
    endtask

`ifdef CDB_AGE_PRIORITY_EN

    task automatic test_age_priority();
        vec_t tbl [3];
        rob_head = 3'd6;
        setFu(0, 3'd1, 16'h1000);
        setFu(1, 3'd7, 16'h1001);
        setFu(2, 3'd6, 16'h1002);
        setFu(3, 3'd0, 16'h1003);
        // Ages FU0..3 = 3,1,0,2
        tbl[0] = '{4'b1111, 4'b0110, 1'b1, 2'd2, 1'b1, 2'd1};
        tbl[1] = '{4'b1001, 4'b1001, 1'b1, 2'd3, 1'b1, 2'd0};
        tbl[2] = '{4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0, 2'd0};
        for (int n = 0; n < 3; n++) begin
            applyStimulus(tbl[n].v, 1'b0);
            numChecks++;
            if (req_ready !== tbl[n].r) begin
                numErrors++;
                $display("[TB] FAIL age_ready[%0d]: got %b expected %b", n, req_ready, tbl[n].r);
            end
            advance();
            numChecks++;
            if (tbl[n].e0 ? ({cdb0_valid, cdb0_src, cdb0_tag, cdb0_value} !== {1'b1, tbl[n].s0, expTag[tbl[n].s0], expVal[tbl[n].s0]}) : (cdb0_valid !== 1'b0)) begin
                numErrors++;
                $display("[TB] FAIL age_port0[%0d]: got v=%b src=%0d tag=%0d expected v=%b src=%0d", n, cdb0_valid, cdb0_src, cdb0_tag, tbl[n].e0, tbl[n].s0);
            end
            numChecks++;
            if (tbl[n].e1 ? ({cdb1_valid, cdb1_src, cdb1_tag, cdb1_value} !== {1'b1, tbl[n].s1, expTag[tbl[n].s1], expVal[tbl[n].s1]}) : (cdb1_valid !== 1'b0)) begin
                numErrors++;
                $display("[TB] FAIL age_port1[%0d]: got v=%b src=%0d tag=%0d expected v=%b src=%0d", n, cdb1_valid, cdb1_src, cdb1_tag, tbl[n].e1, tbl[n].s1);
            end
        end
        // Equal ages on FU1 and FU2 resolve to the lower index first
        rob_head = 3'd0;
        setFu(1, 3'd2, 16'h2001);
        setFu(2, 3'd2, 16'h2002);
        applyStimulus(4'b0110, 1'b0);
        numChecks++;
        if (req_ready !== 4'b0110) begin
            numErrors++;
            $display("[TB] FAIL age_tie_ready: got %b expected 0110", req_ready);
        end
        advance();
        numChecks++;
        if ({cdb0_valid, cdb0_src, cdb1_valid, cdb1_src} !== {1'b1, 2'd1, 1'b1, 2'd2}) begin
            numErrors++;
            $display("[TB] FAIL age_tie_ports: got src0=%0d src1=%0d expected 1 and 2", cdb0_src, cdb1_src);
        end
    endtask

`else

    task automatic test_fairness();
        vec_t tbl [4];
        tbl[0] = '{4'b1111, 4'b1100, 1'b1, 2'd2, 1'b1, 2'd3};
        tbl[1] = '{4'b1111, 4'b0011, 1'b1, 2'd0, 1'b1, 2'd1};
        tbl[2] = '{4'b1111, 4'b1100, 1'b1, 2'd2, 1'b1, 2'd3};
        tbl[3] = '{4'b1111, 4'b0011, 1'b1, 2'd0, 1'b1, 2'd1};
        for (int n = 0; n < 4; n++) begin
            applyStimulus(tbl[n].v, 1'b0);
            numChecks++;
            if (req_ready !== tbl[n].r) begin
                numErrors++;
                $display("[TB] FAIL fair_ready[%0d]: got %b expected %b", n, req_ready, tbl[n].r);
            end
            advance();
            numChecks++;
            if ({cdb0_valid, cdb0_src, cdb0_tag, cdb0_value} !== {1'b1, tbl[n].s0, expTag[tbl[n].s0], expVal[tbl[n].s0]}) begin
                numErrors++;
                $display("[TB] FAIL fair_port0[%0d]: got v=%b src=%0d tag=%0d val=%h expected src %0d", n, cdb0_valid, cdb0_src, cdb0_tag, cdb0_value, tbl[n].s0);
            end
            numChecks++;
            if ({cdb1_valid, cdb1_src, cdb1_tag, cdb1_value} !== {1'b1, tbl[n].s1, expTag[tbl[n].s1], expVal[tbl[n].s1]}) begin
                numErrors++;
                $display("[TB] FAIL fair_port1[%0d]: got v=%b src=%0d tag=%0d val=%h expected src %0d", n, cdb1_valid, cdb1_src, cdb1_tag, cdb1_value, tbl[n].s1);
            end
        end
    endtask

    task automatic test_wrap_single();
        vec_t tbl [4];
        setFu(0, 3'd5, 16'h0010);
        // Pointer starts at 2: FU2 alone moves it to 3, FU0 alone wraps it to 1
        tbl[0] = '{4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0, 2'd0};
        tbl[1] = '{4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0, 2'd0};
        tbl[2] = '{4'b1111, 4'b0110, 1'b1, 2'd1, 1'b1, 2'd2};
        tbl[3] = '{4'b1111, 4'b1001, 1'b1, 2'd3, 1'b1, 2'd0};
        for (int n = 0; n < 4; n++) begin
            applyStimulus(tbl[n].v, 1'b0);
            numChecks++;
            if (req_ready !== tbl[n].r) begin
                numErrors++;
                $display("[TB] FAIL wrap_ready[%0d]: got %b expected %b", n, req_ready, tbl[n].r);
            end
            advance();
            numChecks++;
            if ({cdb0_valid, cdb0_src, cdb0_tag, cdb0_value} !== {1'b1, tbl[n].s0, expTag[tbl[n].s0], expVal[tbl[n].s0]}) begin
                numErrors++;
                $display("[TB] FAIL wrap_port0[%0d]: got v=%b src=%0d tag=%0d val=%h expected src %0d", n, cdb0_valid, cdb0_src, cdb0_tag, cdb0_value, tbl[n].s0);
            end
            numChecks++;
            if (tbl[n].e1 ? ({cdb1_valid, cdb1_src, cdb1_tag, cdb1_value} !== {1'b1, tbl[n].s1, expTag[tbl[n].s1], expVal[tbl[n].s1]}) : (cdb1_valid !== 1'b0)) begin
                numErrors++;
                $display("[TB] FAIL wrap_port1[%0d]: got v=%b src=%0d expected v=%b src=%0d", n, cdb1_valid, cdb1_src, tbl[n].e1, tbl[n].s1);
            end
        end
    endtask

    task automatic test_flush();
        // Pointer is 1 and the CDB still carries the (3,0) pair from the previous grant
        applyStimulus(4'b0110, 1'b1);
        numChecks++;
        if (req_ready !== 4'b0000) begin
            numErrors++;
            $display("[TB] FAIL flush_ready: got %b expected 0000", req_ready);
        end
        numChecks++;
        if ({cdb0_valid, cdb0_src, cdb1_valid, cdb1_src} !== {1'b1, 2'd3, 1'b1, 2'd0}) begin
            numErrors++;
            $display("[TB] FAIL flush_launched: got v0=%b src0=%0d v1=%b src1=%0d expected 1/3 1/0", cdb0_valid, cdb0_src, cdb1_valid, cdb1_src);
        end
        advance();
        numChecks++;
        if ({cdb0_valid, cdb1_valid} !== 2'b00) begin
            numErrors++;
            $display("[TB] FAIL flush_valids: got %b%b expected 00", cdb0_valid, cdb1_valid);
        end
        applyStimulus(4'b1111, 1'b0);
        numChecks++;
        if (req_ready !== 4'b0110) begin
            numErrors++;
            $display("[TB] FAIL post_flush_ready: got %b expected 0110", req_ready);
        end
        advance();
        numChecks++;
        if ({cdb0_valid, cdb0_src, cdb1_valid, cdb1_src} !== {1'b1, 2'd1, 1'b1, 2'd2}) begin
            numErrors++;
            $display("[TB] FAIL post_flush_ports: got v0=%b src0=%0d v1=%b src1=%0d expected 1/1 1/2", cdb0_valid, cdb0_src, cdb1_valid, cdb1_src);
        end
    endtask

    task automatic test_idle();
        for (int n = 0; n < 3; n++) begin
            applyStimulus(4'b0000, 1'b0);
            numChecks++;
            if (req_ready !== 4'b0000) begin
                numErrors++;
                $display("[TB] FAIL idle_ready[%0d]: got %b expected 0000", n, req_ready);
            end
            advance();
            numChecks++;
            if ({cdb0_valid, cdb1_valid} !== 2'b00) begin
                numErrors++;
                $display("[TB] FAIL idle_valids[%0d]: got %b%b expected 00", n, cdb0_valid, cdb1_valid);
            end
        end
        // Pointer held at 3 across the idle cycles
        applyStimulus(4'b1111, 1'b0);
        numChecks++;
        if (req_ready !== 4'b1001) begin
            numErrors++;
            $display("[TB] FAIL idle_resume_ready: got %b expected 1001", req_ready);
        end
        advance();
        numChecks++;
        if ({cdb0_valid, cdb0_src, cdb1_valid, cdb1_src} !== {1'b1, 2'd3, 1'b1, 2'd0}) begin
            numErrors++;
            $display("[TB] FAIL idle_resume_ports: got src0=%0d src1=%0d expected 3 and 0", cdb0_src, cdb1_src);
        end
    endtask

    task automatic test_flush_during_reset();
        applyStimulus(4'b1111, 1'b1);
        rst = 1'b0;
        #1;
        numChecks++;
        if ({req_ready, cdb0_valid, cdb1_valid} !== 6'b0) begin
            numErrors++;
            $display("[TB] FAIL rst_flush_outputs: got ready=%b v0=%b v1=%b expected all zero", req_ready, cdb0_valid, cdb1_valid);
        end
        advance();
        rst = 1'b1;
        applyStimulus(4'b1111, 1'b0);
        numChecks++;
        if (req_ready !== 4'b0011) begin
            numErrors++;
            $display("[TB] FAIL rst_flush_ptr: got %b expected 0011", req_ready);
        end
        advance();
        numChecks++;
        if ({cdb0_valid, cdb0_src, cdb1_valid, cdb1_src} !== {1'b1, 2'd0, 1'b1, 2'd1}) begin
            numErrors++;
            $display("[TB] FAIL rst_flush_ports: got src0=%0d src1=%0d expected 0 and 1", cdb0_src, cdb1_src);
        end
    endtask

`endif

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
`ifdef CDB_AGE_PRIORITY_EN
        test_age_priority();
`else
        test_fairness();
        test_wrap_single();
        test_flush();
        test_idle();
        test_flush_during_reset();
`endif
        applyStimulus(4'b0000, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
